fsm_fib_seq: RTL and testbench

FSM_FIB_SEQ -- requirements
Module: fsm_fib_seq

---
 rtl/fsm_fib_seq_pkg.sv | 20 ++
 rtl/fib_idx_ring.sv | 46 ++++
 rtl/fsm_fib_seq.sv | 166 ++++++++++++++++
 tb/tb_fsm_fib_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fsm_fib_seq_pkg.sv
// fsm_fib_seq_pkg -- shared types and ALU encodings for the Fibonacci sequencer.
//   fib_state_e : sequencer state encoding
//   ALU_MOVI    : upper byte of the move-immediate instruction word
//   ALU_ADD     : register + register instruction word
//   ALU_NOP     : idle instruction word
package fsm_fib_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED0 = 3'd1,
    S_SEED1 = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } fib_state_e;

  localparam logic [7:0]  ALU_MOVI = 8'hD0;
  localparam logic [15:0] ALU_ADD  = 16'h0050;
  localparam logic [15:0] ALU_NOP  = 16'h0000;

endpackage

// File: rtl/fib_idx_ring.sv
// fib_idx_ring -- three modulo-NREG register index counters for the RUN phase.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   clr_i  : reload to the first RUN term (dst=2, a=0, b=1)
//   en_i   : advance all three indices by one, wrapping at NREG
//   dst_o  : destination register index
//   a_o    : operand A register index
//   b_o    : operand B register index
module fib_idx_ring #(
  parameter int NREG = 16,
  parameter int SELW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [SELW-1:0] dst_o,
  output logic [SELW-1:0] a_o,
  output logic [SELW-1:0] b_o
);

  logic [SELW-1:0] dst_q, a_q, b_q;

  // Explicit compare-and-clear so NREG need not be a power of two.
  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] x);
    return (x == SELW'(NREG - 1)) ? '0 : x + SELW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      dst_q <= SELW'(2);
      a_q   <= '0;
      b_q   <= SELW'(1);
    end else if (en_i) begin
      dst_q <= wrap_inc(dst_q);
      a_q   <= wrap_inc(a_q);
      b_q   <= wrap_inc(b_q);
    end
  end

  assign dst_o = dst_q;
  assign a_o   = a_q;
  assign b_o   = b_q;

endmodule

// File: rtl/fsm_fib_seq.sv
// fsm_fib_seq -- sequencer that drives a register file + ALU to generate a
// Fibonacci sequence of len terms from two immediate seeds.
// Build option: FSM_FIB_SEQ_OVF_ABORT_EN -- abort the run with err on an ALU
// carry during an unstalled RUN write; otherwise alu_carry is ignored.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   start, len, seed0, seed1  : run request and its parameters (sampled in IDLE)
//   stall                     : hold the datapath (no write, state frozen)
//   alu_carry                 : ALU carry-out of the current write
//   RegEnable                 : one-hot register write enable
//   MuxControlA/B             : ALU operand register selects
//   MuxControlC               : operand B source (1 = immediate)
//   AluControl                : ALU instruction word
//   busy, done, err           : status
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | waiting for start
// S_SEED0 | write seed0 into r0 (MOVI)
// S_SEED1 | write seed1 into r1 (MOVI)
// S_RUN   | write term k = r[k-2] + r[k-1] into r[k mod NREG]
// S_DONE  | one-cycle done (and err on overflow abort)
module fsm_fib_seq
  import fsm_fib_seq_pkg::*;
#(
  parameter int NREG = 16,
  parameter int LENW = 8,
  parameter int SELW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LENW-1:0] len,
  input  logic [7:0]      seed0,
  input  logic [7:0]      seed1,
  input  logic            stall,
  input  logic            alu_carry,
  output logic [NREG-1:0] RegEnable,
  output logic [SELW-1:0] MuxControlA,
  output logic [SELW-1:0] MuxControlB,
  output logic            MuxControlC,
  output logic [15:0]     AluControl,
  output logic            busy,
  output logic            done,
  output logic            err
);

  fib_state_e      state_q;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] k_q;
  logic [7:0]      seed0_q, seed1_q;
  logic            err_q;

  logic [SELW-1:0] dst_idx, a_idx, b_idx;
  logic            ring_en_d, ring_clr_d;
  logic            ovf_abort_d;

`ifdef FSM_FIB_SEQ_OVF_ABORT_EN
  assign ovf_abort_d = alu_carry;
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_carry;
  assign ovf_abort_d      = 1'b0;
`endif

  // Ring sits at the first RUN term whenever we are outside RUN.
  assign ring_en_d  = (state_q == S_RUN) && !stall;
  assign ring_clr_d = (state_q != S_RUN);

  fib_idx_ring #(.NREG(NREG), .SELW(SELW)) u_ring (
    .clk   (clk),
    .reset (reset),
    .clr_i (ring_clr_d),
    .en_i  (ring_en_d),
    .dst_o (dst_idx),
    .a_o   (a_idx),
    .b_o   (b_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      k_q     <= '0;
      seed0_q <= '0;
      seed1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q   <= len;
            seed0_q <= seed0;
            seed1_q <= seed1;
            k_q     <= '0;
            state_q <= (len == '0) ? S_DONE : S_SEED0;
          end
        end
        S_SEED0: begin
          if (!stall) begin
            k_q     <= LENW'(1);
            state_q <= (len_q >= LENW'(2)) ? S_SEED1 : S_DONE;
          end
        end
        S_SEED1: begin
          if (!stall) begin
            k_q     <= LENW'(2);
            state_q <= (len_q >= LENW'(3)) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (ovf_abort_d) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (k_q == len_q - LENW'(1)) begin
              state_q <= S_DONE;
            end else begin
              k_q <= k_q + LENW'(1);
            end
          end
        end
        S_DONE: begin
          k_q     <= '0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode; stall only masks the write strobe, selects stay put.
  always_comb begin
    RegEnable   = '0;
    MuxControlA = '0;
    MuxControlB = '0;
    MuxControlC = 1'b0;
    AluControl  = ALU_NOP;
    unique case (state_q)
      S_SEED0: begin
        RegEnable   = stall ? '0 : NREG'(1);
        MuxControlC = 1'b1;
        AluControl  = {ALU_MOVI, seed0_q};
      end
      S_SEED1: begin
        RegEnable   = stall ? '0 : NREG'(2);
        MuxControlA = SELW'(1);
        MuxControlC = 1'b1;
        AluControl  = {ALU_MOVI, seed1_q};
      end
      S_RUN: begin
        RegEnable   = stall ? '0 : (NREG'(1) << dst_idx);
        MuxControlA = a_idx;
        MuxControlB = b_idx;
        AluControl  = ALU_ADD;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_fsm_fib_seq.sv
// tb_fsm_fib_seq -- directed self-checking bench for fsm_fib_seq.
// Two instances (NREG=16 and NREG=5) share the stimulus; use5 selects
// which one the checks observe.
module tb_fsm_fib_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic [7:0] seed0, seed1;
  logic       stall;
  logic       alu_carry;

  logic [15:0] re16;
  logic [3:0]  a16, b16;
  logic        c16, busy16, done16, err16;
  logic [15:0] alu16;

  logic [4:0]  re5;
  logic [2:0]  a5, b5;
  logic        c5, busy5, done5, err5;
  logic [15:0] alu5;

  logic        use5;
  logic [15:0] re_o;
  logic [3:0]  a_o, b_o;
  logic        c_o, busy_o, done_o, err_o;
  logic [15:0] alu_o;

  logic [15:0] regs [16];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsm_fib_seq #(.NREG(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .seed0(seed0), .seed1(seed1), .stall(stall), .alu_carry(alu_carry),
    .RegEnable(re16), .MuxControlA(a16), .MuxControlB(b16),
    .MuxControlC(c16), .AluControl(alu16),
    .busy(busy16), .done(done16), .err(err16)
  );

  fsm_fib_seq #(.NREG(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .seed0(seed0), .seed1(seed1), .stall(stall), .alu_carry(alu_carry),
    .RegEnable(re5), .MuxControlA(a5), .MuxControlB(b5),
    .MuxControlC(c5), .AluControl(alu5),
    .busy(busy5), .done(done5), .err(err5)
  );

  always_comb begin
    if (use5) begin
      re_o = {11'b0, re5}; a_o = {1'b0, a5}; b_o = {1'b0, b5};
      c_o = c5; alu_o = alu5; busy_o = busy5; done_o = done5; err_o = err5;
    end else begin
      re_o = re16; a_o = a16; b_o = b16;
      c_o = c16; alu_o = alu16; busy_o = busy16; done_o = done16; err_o = err16;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(busy_o), 32'd0);
    chk({tag, " re"},   32'(re_o),   32'd0);
    chk({tag, " a"},    32'(a_o),    32'd0);
    chk({tag, " b"},    32'(b_o),    32'd0);
    chk({tag, " c"},    32'(c_o),    32'd0);
    chk({tag, " alu"},  32'(alu_o),  32'h0000);
    chk({tag, " done"}, 32'(done_o), 32'd0);
    chk({tag, " err"},  32'(err_o),  32'd0);
  endtask

  // One full run: accept, walk every term with expected values, then done.
  task automatic run_seq(input int nreg, input int n, input logic [7:0] s0,
                         input logic [7:0] s1, input int stall_k, input int stall_n);
    int dst, ea, eb;
    logic ec;
    logic [15:0] exp_alu;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    use5 = (nreg == 5);
    start = 1'b1; len = 8'(n); seed0 = s0; seed1 = s1;
    tick();
    // Scramble the request inputs; a correct sequencer already latched them.
    start = 1'b0; len = 8'hFF; seed0 = 8'h00; seed1 = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (k < 2) begin
        dst = k; ea = k; eb = 0; ec = 1'b1;
        exp_alu = {8'hD0, (k == 0) ? s0 : s1};
      end else begin
        dst = k % nreg; ea = (k - 2) % nreg; eb = (k - 1) % nreg; ec = 1'b0;
        exp_alu = 16'h0050;
      end
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) begin
          stall = 1'b1;
          if (s == 0) begin start = 1'b1; len = 8'd3; end
          #1;
          chk($sformatf("stall re k=%0d", k),  32'(re_o),  32'd0);
          chk($sformatf("stall a k=%0d", k),   32'(a_o),   32'(ea));
          chk($sformatf("stall b k=%0d", k),   32'(b_o),   32'(eb));
          chk($sformatf("stall alu k=%0d", k), 32'(alu_o), 32'(exp_alu));
          tick();
          start = 1'b0; len = 8'hFF;
        end
        stall = 1'b0;
      end
      #1;
      chk($sformatf("re k=%0d", k),   32'(re_o),   32'(1) << dst);
      chk($sformatf("a k=%0d", k),    32'(a_o),    32'(ea));
      if (k >= 2) chk($sformatf("b k=%0d", k), 32'(b_o), 32'(eb));
      chk($sformatf("c k=%0d", k),    32'(c_o),    32'(ec));
      chk($sformatf("alu k=%0d", k),  32'(alu_o),  32'(exp_alu));
      chk($sformatf("busy k=%0d", k), 32'(busy_o), 32'd1);
      chk($sformatf("done k=%0d", k), 32'(done_o), 32'd0);
      // Register-file model driven by the DUT's own selects.
      for (int i = 0; i < 16; i++)
        if (re_o[i]) regs[i] = c_o ? {8'h00, alu_o[7:0]} : regs[a_o] + regs[b_o];
      tick();
    end
    #1;
    chk($sformatf("end done n=%0d", n), 32'(done_o), 32'd1);
    chk($sformatf("end err n=%0d", n),  32'(err_o),  32'd0);
    chk($sformatf("end re n=%0d", n),   32'(re_o),   32'd0);
    chk($sformatf("end busy n=%0d", n), 32'(busy_o), 32'd1);
    tick();
    chk($sformatf("post done n=%0d", n), 32'(done_o), 32'd0);
    chk($sformatf("post busy n=%0d", n), 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    use5 = 1'b0; reset = 1'b1; start = 1'b0; len = '0;
    seed0 = '0; seed1 = '0; stall = 1'b0; alu_carry = 1'b0;
    tick(); tick();
    chk_idle("reset");
    reset = 1'b0;
    tick();

    // Full 16-term run on NREG=16.
    run_seq(16, 16, 8'd1, 8'd2, -1, 0);
    chk("r14 value", 32'(regs[14]), 32'd987);
    chk("r15 value", 32'(regs[15]), 32'd1597);

    // Wrap on NREG=5; carry must be ignored in the default build.
`ifndef FSM_FIB_SEQ_OVF_ABORT_EN
    alu_carry = 1'b1;
`endif
    run_seq(5, 9, 8'd3, 8'd4, -1, 0);
    alu_carry = 1'b0;

    // Short runs.
    run_seq(16, 0, 8'h11, 8'h22, -1, 0);
    run_seq(16, 1, 8'h33, 8'h44, -1, 0);
    run_seq(16, 2, 8'h55, 8'h66, -1, 0);

    // Stall 3 cycles at k=4, second start during the stall.
    run_seq(16, 8, 8'd1, 8'd1, 4, 3);
    chk("stall run r7", 32'(regs[7]), 32'd21);

    // Reset at k=7 aborts without done.
    use5 = 1'b0;
    start = 1'b1; len = 8'd10; seed0 = 8'd1; seed1 = 8'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("pre-reset re k=7", 32'(re_o), 32'h0080);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("mid reset");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("no done after reset %0d", i), 32'(done_o), 32'd0);
    end

`ifdef FSM_FIB_SEQ_OVF_ABORT_EN
    // Carry at k=6: r6 written, then done+err, no r7 write.
    start = 1'b1; len = 8'd10; seed0 = 8'd1; seed1 = 8'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    alu_carry = 1'b1;
    #1;
    chk("ovf re k=6", 32'(re_o), 32'h0040);
    tick();
    alu_carry = 1'b0;
    chk("ovf done", 32'(done_o), 32'd1);
    chk("ovf err",  32'(err_o),  32'd1);
    chk("ovf re",   32'(re_o),   32'd0);
    tick();
    chk("ovf post done", 32'(done_o), 32'd0);
    chk("ovf post err",  32'(err_o),  32'd0);
    chk("ovf post busy", 32'(busy_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
